// File: rtl/time_setter_pkg.sv
// Shared definitions for the time setter: FSM encoding, field codes,
// time limits and the clamp/step helpers used on the shadow registers.
package time_setter_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_EDIT_HOUR = 3'd1,
    S_EDIT_MIN  = 3'd2,
    S_EDIT_AMPM = 3'd3,
    S_WR_HOUR   = 3'd4,
    S_WR_MIN    = 3'd5,
    S_WR_AMPM   = 3'd6
  } state_t;

  localparam logic [1:0] FIELD_NONE = 2'd0;
  localparam logic [1:0] FIELD_HOUR = 2'd1;
  localparam logic [1:0] FIELD_MIN  = 2'd2;
  localparam logic [1:0] FIELD_AMPM = 2'd3;

  localparam logic [7:0] HOUR_MIN = 8'd1;
  localparam logic [7:0] HOUR_MAX = 8'd12;
  localparam logic [7:0] MIN_MAX  = 8'd59;

  function automatic logic [7:0] clamp_hour(input logic [7:0] h);
    if (h == 8'd0 || h > HOUR_MAX) return HOUR_MAX;
    else return h;
  endfunction

  function automatic logic [7:0] clamp_min(input logic [7:0] m);
    if (m > MIN_MAX) return 8'd0;
    else return m;
  endfunction

  function automatic logic [7:0] hour_step(input logic [7:0] h, input logic up);
    if (up) return (h >= HOUR_MAX) ? HOUR_MIN : h + 8'd1;
    else return (h <= HOUR_MIN) ? HOUR_MAX : h - 8'd1;
  endfunction

  function automatic logic [7:0] min_step(input logic [7:0] m, input logic up);
    if (up) return (m >= MIN_MAX) ? 8'd0 : m + 8'd1;
    else return (m == 8'd0) ? MIN_MAX : m - 8'd1;
  endfunction

endpackage

// File: rtl/time_setter_button_conditioner.sv
// Raw button -> 2-flop synchronizer -> debounced level -> one-cycle pulse
// on each accepted rising edge.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_btn,
  output logic o_pulse
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    r_sync;
  logic          r_level;
  logic [CW-1:0] r_cnt;
  logic          r_pulse;

  // Counter tracks consecutive samples that disagree with the accepted level.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync  <= 2'b00;
      r_level <= 1'b0;
      r_cnt   <= '0;
      r_pulse <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], i_btn};
      r_pulse <= 1'b0;
      if (r_sync[1] == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_level <= r_sync[1];
        r_cnt   <= '0;
        r_pulse <= r_sync[1];
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/time_setter.sv
// Button-driven editor for a 12-hour clock: captures the current time into
// shadows, lets the user step each field, then commits with three strobes.
module time_setter
  import time_setter_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int TIMEOUT_CYCLES  = 500000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btnMode,
  input  logic       btnUp,
  input  logic       btnDown,
  input  logic [7:0] curHour,
  input  logic [7:0] curMin,
  input  logic       curAmpm,
  output logic       writeHour,
  output logic       writeMin,
  output logic       writeAmpm,
  output logic [7:0] data,
  output logic       editing,
  output logic [1:0] field
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic w_mode, w_up, w_down;
  logic w_in_edit, w_any_pulse, w_timeout;
  state_t r_state, w_state_next;
  logic [TW-1:0] r_to_cnt;
  logic [7:0] r_hour, r_min;
  logic r_ampm;
  logic w_wr_hour, w_wr_min, w_wr_ampm, w_editing;
  logic [7:0] w_data;
  logic [1:0] w_field;
  logic r_wr_hour, r_wr_min, r_wr_ampm, r_editing;
  logic [7:0] r_data;
  logic [1:0] r_field;

  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_mode (
    .clk(clk), .reset(reset), .i_btn(btnMode), .o_pulse(w_mode));
  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_up (
    .clk(clk), .reset(reset), .i_btn(btnUp), .o_pulse(w_up));
  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_down (
    .clk(clk), .reset(reset), .i_btn(btnDown), .o_pulse(w_down));

  assign w_in_edit   = (r_state == S_EDIT_HOUR) || (r_state == S_EDIT_MIN) ||
                       (r_state == S_EDIT_AMPM);
  assign w_any_pulse = w_mode | w_up | w_down;
  assign w_timeout   = w_in_edit && !w_any_pulse && (r_to_cnt == TO_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Next state: mode outranks up/down, then up+down cancel, then timeout.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:      w_state_next = w_mode ? S_EDIT_HOUR : S_IDLE;
      S_EDIT_HOUR: w_state_next = w_mode ? S_EDIT_MIN :
                                  ((w_up && w_down) || w_timeout) ? S_IDLE : S_EDIT_HOUR;
      S_EDIT_MIN:  w_state_next = w_mode ? S_EDIT_AMPM :
                                  ((w_up && w_down) || w_timeout) ? S_IDLE : S_EDIT_MIN;
      S_EDIT_AMPM: w_state_next = w_mode ? S_WR_HOUR :
                                  ((w_up && w_down) || w_timeout) ? S_IDLE : S_EDIT_AMPM;
      S_WR_HOUR:   w_state_next = S_WR_MIN;
      S_WR_MIN:    w_state_next = S_WR_AMPM;
      S_WR_AMPM:   w_state_next = S_IDLE;
      default:     w_state_next = S_IDLE;
    endcase
  end

  // Idle-cycle counter for abandoning an edit.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_to_cnt <= '0;
    end else if (!w_in_edit || w_any_pulse || (w_state_next != r_state)) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + TW'(1);
    end
  end

  // Shadow registers: capture on entry, step only on a lone up or down.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hour <= HOUR_MAX;
      r_min  <= 8'd0;
      r_ampm <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_mode) begin
            r_hour <= clamp_hour(curHour);
            r_min  <= clamp_min(curMin);
            r_ampm <= curAmpm;
          end
        end
        S_EDIT_HOUR: if (!w_mode && (w_up ^ w_down)) r_hour <= hour_step(r_hour, w_up);
        S_EDIT_MIN:  if (!w_mode && (w_up ^ w_down)) r_min <= min_step(r_min, w_up);
        S_EDIT_AMPM: if (!w_mode && (w_up ^ w_down)) r_ampm <= ~r_ampm;
        default: begin
        end
      endcase
    end
  end

  // Outputs decoded from the next state so the registered copies line up with it.
  always_comb begin
    w_wr_hour = 1'b0;
    w_wr_min  = 1'b0;
    w_wr_ampm = 1'b0;
    w_data    = 8'd0;
    w_editing = (w_state_next != S_IDLE);
    w_field   = FIELD_NONE;
    case (w_state_next)
      S_EDIT_HOUR: w_field = FIELD_HOUR;
      S_EDIT_MIN:  w_field = FIELD_MIN;
      S_EDIT_AMPM: w_field = FIELD_AMPM;
      S_WR_HOUR: begin
        w_wr_hour = 1'b1;
        w_data    = r_hour;
      end
      S_WR_MIN: begin
        w_wr_min = 1'b1;
        w_data   = r_min;
      end
      S_WR_AMPM: begin
        w_wr_ampm = 1'b1;
        w_data    = {7'b0, r_ampm};
      end
      default: w_field = FIELD_NONE;
    endcase
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_hour <= 1'b0;
      r_wr_min  <= 1'b0;
      r_wr_ampm <= 1'b0;
      r_data    <= 8'd0;
      r_editing <= 1'b0;
      r_field   <= FIELD_NONE;
    end else begin
      r_wr_hour <= w_wr_hour;
      r_wr_min  <= w_wr_min;
      r_wr_ampm <= w_wr_ampm;
      r_data    <= w_data;
      r_editing <= w_editing;
      r_field   <= w_field;
    end
  end

  assign writeHour = r_wr_hour;
  assign writeMin  = r_wr_min;
  assign writeAmpm = r_wr_ampm;
  assign data      = r_data;
  assign editing   = r_editing;
  assign field     = r_field;

endmodule

// File: tb/tb_time_setter.sv
// Scoreboard bench for time_setter: expected writes are queued as commits are
// requested and popped by a negedge monitor as strobes appear.
module tb_time_setter;

  logic       clk = 1'b0;
  logic       reset, btnMode, btnUp, btnDown;
  logic [7:0] curHour, curMin;
  logic       curAmpm;
  logic       writeHour, writeMin, writeAmpm;
  logic [7:0] data;
  logic       editing;
  logic [1:0] field;

  time_setter #(.DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(200)) dut (
    .clk(clk), .reset(reset), .btnMode(btnMode), .btnUp(btnUp), .btnDown(btnDown),
    .curHour(curHour), .curMin(curMin), .curAmpm(curAmpm),
    .writeHour(writeHour), .writeMin(writeMin), .writeAmpm(writeAmpm),
    .data(data), .editing(editing), .field(field));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] kind;
    logic [7:0] val;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  strobe_total = 0;
  int  t_hour = -1, t_min = -1, t_ampm = -1;
  bit  mon_en = 1'b0;
  int  m_hour, m_min, m_ampm;

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor / scoreboard consumer.
  always @(negedge clk) begin
    if (mon_en) begin
      int  n;
      wr_t got, e;
      n = int'(writeHour) + int'(writeMin) + int'(writeAmpm);
      checks++;
      if (n > 1) begin
        errors++;
        $display("FAIL strobe_exclusive: got h=%0b m=%0b a=%0b, need at most one",
                 writeHour, writeMin, writeAmpm);
      end else if (n == 0) begin
        if (data !== 8'd0) begin
          errors++;
          $display("FAIL idle_data: got %0d, need 0", data);
        end
      end else begin
        got.kind = writeHour ? 2'd1 : (writeMin ? 2'd2 : 2'd3);
        got.val  = data;
        strobe_total++;
        if (writeHour) t_hour = cyc;
        if (writeMin)  t_min  = cyc;
        if (writeAmpm) t_ampm = cyc;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: got kind=%0d data=%0d, need none", got.kind, got.val);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            errors++;
            $display("FAIL write_payload: got kind=%0d data=%0d, need kind=%0d data=%0d",
                     got.kind, got.val, e.kind, e.val);
          end
        end
      end
    end
  end

  function automatic int mh_up(int h); return (h % 12) + 1; endfunction
  function automatic int mh_dn(int h); return (h == 1) ? 12 : h - 1; endfunction
  function automatic int mm_up(int m); return (m + 1) % 60; endfunction
  function automatic int mm_dn(int m); return (m + 59) % 60; endfunction
  function automatic int cl_h(int h); return (h == 0 || h > 12) ? 12 : h; endfunction
  function automatic int cl_m(int m); return (m > 59) ? 0 : m; endfunction

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic m, input logic u, input logic d);
    btnMode = m; btnUp = u; btnDown = d;
    cycles(10);
    btnMode = 1'b0; btnUp = 1'b0; btnDown = 1'b0;
    cycles(10);
  endtask

  task automatic start_edit(input int h, input int mi, input int ap);
    curHour = 8'(h); curMin = 8'(mi); curAmpm = ap[0];
    m_hour = cl_h(h); m_min = cl_m(mi); m_ampm = ap;
    press(1'b1, 1'b0, 1'b0);
  endtask

  task automatic commit(input string name);
    exp_q.push_back({2'd1, 8'(m_hour)});
    exp_q.push_back({2'd2, 8'(m_min)});
    exp_q.push_back({2'd3, 8'(m_ampm)});
    press(1'b1, 1'b0, 1'b0);
    cycles(5);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: got %0d pending writes, need 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; btnMode = 1'b0; btnUp = 1'b0; btnDown = 1'b0;
    curHour = 8'd0; curMin = 8'd0; curAmpm = 1'b0;
    cycles(3);
    checks++;
    if ({writeHour, writeMin, writeAmpm, data, editing, field} !== 13'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b, need 0", {writeHour, writeMin, writeAmpm, data, editing, field});
    end
    mon_en = 1'b1;
    reset = 1'b0;
    cycles(3);
  endtask

  task automatic test_idle_ignore;
    press(1'b0, 1'b1, 1'b0);
    press(1'b0, 1'b0, 1'b1);
    checks++;
    if (editing !== 1'b0 || strobe_total != 0) begin
      errors++;
      $display("FAIL idle_ignore: got editing=%b strobes=%0d, need 0/0", editing, strobe_total);
    end
  endtask

  task automatic test_full_edit;
    int s0;
    start_edit(11, 58, 1);
    checks++;
    if (field !== 2'd1 || editing !== 1'b1) begin
      errors++;
      $display("FAIL full_enter: got field=%0d editing=%b, need 1/1", field, editing);
    end
    repeat (2) begin press(1'b0, 1'b1, 1'b0); m_hour = mh_up(m_hour); end
    press(1'b1, 1'b0, 1'b0);
    checks++;
    if (field !== 2'd2) begin
      errors++;
      $display("FAIL full_field_min: got %0d, need 2", field);
    end
    repeat (3) begin press(1'b0, 1'b1, 1'b0); m_min = mm_up(m_min); end
    press(1'b1, 1'b0, 1'b0);
    checks++;
    if (field !== 2'd3) begin
      errors++;
      $display("FAIL full_field_ampm: got %0d, need 3", field);
    end
    press(1'b0, 1'b0, 1'b1); m_ampm = 1 - m_ampm;
    s0 = strobe_total;
    commit("full");
    checks++;
    if (strobe_total - s0 != 3 || t_min != t_hour + 1 || t_ampm != t_min + 1) begin
      errors++;
      $display("FAIL full_commit_timing: got n=%0d h@%0d m@%0d a@%0d, need 3 consecutive",
               strobe_total - s0, t_hour, t_min, t_ampm);
    end
    checks++;
    if (editing !== 1'b0 || field !== 2'd0) begin
      errors++;
      $display("FAIL full_idle: got editing=%b field=%0d, need 0/0", editing, field);
    end
  endtask

  task automatic test_wrap;
    start_edit(1, 0, 0);
    press(1'b0, 1'b0, 1'b1); m_hour = mh_dn(m_hour);
    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b0, 1'b1); m_min = mm_dn(m_min);
    press(1'b1, 1'b0, 1'b0);
    commit("wrap_down");
    start_edit(5, 59, 0);
    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b0); m_min = mm_up(m_min);
    press(1'b1, 1'b0, 1'b0);
    commit("wrap_up");
  endtask

  task automatic test_clamp;
    int tbl_h[3] = '{0, 13, 12};
    int tbl_m[3] = '{75, 60, 59};
    for (int i = 0; i < 3; i++) begin
      start_edit(tbl_h[i], tbl_m[i], i % 2);
      press(1'b1, 1'b0, 1'b0);
      press(1'b1, 1'b0, 1'b0);
      commit("clamp");
    end
  endtask

  task automatic test_bounce;
    start_edit(3, 10, 0);
    btnUp = 1'b0;
    for (int i = 0; i < 10; i++) begin
      btnUp = ~btnUp;
      cycles(2);
    end
    btnUp = 1'b1;
    cycles(10);
    btnUp = 1'b0;
    cycles(10);
    m_hour = mh_up(m_hour);
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    commit("bounce");
  endtask

  task automatic test_cancel;
    int s0;
    start_edit(4, 20, 1);
    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b1);
    checks++;
    if (editing !== 1'b0 || field !== 2'd0) begin
      errors++;
      $display("FAIL cancel_idle: got editing=%b field=%0d, need 0/0", editing, field);
    end
    s0 = strobe_total;
    cycles(50);
    checks++;
    if (strobe_total != s0) begin
      errors++;
      $display("FAIL cancel_no_write: got %0d strobes, need 0", strobe_total - s0);
    end
  endtask

  task automatic test_timeout;
    int n, s0;
    bit seen;
    s0 = strobe_total;
    curHour = 8'd7; curMin = 8'd7; curAmpm = 1'b0;
    btnMode = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (field === 2'd1) seen = 1'b1;
    end
    btnMode = 1'b0;
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL timeout_enter: got field=%0d, need 1", field);
    end
    n = 0;
    while (n < 300 && editing === 1'b1) begin
      @(negedge clk);
      n++;
      if (n == 10) btnMode = 1'b0;
    end
    checks++;
    if (n != 200) begin
      errors++;
      $display("FAIL timeout_cycles: got %0d, need 200", n);
    end
    cycles(20);
    checks++;
    if (editing !== 1'b0 || strobe_total != s0) begin
      errors++;
      $display("FAIL timeout_idle: got editing=%b strobes=%0d, need 0/0", editing, strobe_total - s0);
    end
  endtask

  task automatic test_reset_mid_commit;
    bit seen;
    int amp;
    start_edit(6, 30, 1);
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    exp_q.push_back({2'd1, 8'(m_hour)});
    exp_q.push_back({2'd2, 8'(m_min)});
    btnMode = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (writeMin === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL rst_commit_reach: got writeMin=%b, need 1", writeMin);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({writeHour, writeMin, writeAmpm, data, editing, field} !== 13'd0) begin
      errors++;
      $display("FAIL rst_commit_outputs: got %b, need 0", {writeHour, writeMin, writeAmpm, data, editing, field});
    end
    btnMode = 1'b0;
    cycles(3);
    reset = 1'b0;
    amp = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (writeAmpm === 1'b1) amp++;
    end
    checks++;
    if (amp != 0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL rst_commit_no_ampm: got ampm=%0d pending=%0d, need 0/0", amp, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_idle_ignore();
    test_full_edit();
    test_wrap();
    test_clamp();
    test_bounce();
    test_cancel();
    test_timeout();
    test_reset_mid_commit();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion, need finish");
    $fatal(1);
  end

endmodule
